input_module: RTL and testbench

// Router input port: receiver end of the link that output_module drives. Accepts flits from the

---
 rtl/input_module.sv | 261 ++++++++++++++++++++++++++
 tb/tb_input_module.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_module.sv
// -----------------------------------------------------------------------------
// input_module
//
// Router input port. Receives flits from the upstream router into one FIFO per
// virtual channel, tells the upstream which VCs can take another flit, works out
// the XY output port from each head flit, and offers one buffered flit per cycle
// to the crossbar. The VCs take turns round-robin.
//
// Ports
//   clk           in   1      clock, rising edge
//   arst          in   1      asynchronous reset, active-low
//   fin_req_i     in   37     link flit: [0] valid, [2:1] vc id, [36:3] flit
//   fin_resp_o    out  N_VC   per-VC ready to upstream (1 = FIFO not full)
//   fout_req_o    out  37     flit to crossbar: [0] valid, [2:1] vc, [36:3] flit
//   fout_route_o  out  5      one-hot output port: [0]L [1]N [2]S [3]E [4]W
//   fout_resp_i   in   1      crossbar accepts fout_req_o this cycle
//   err_o         out  1      one-cycle pulse on protocol error or dropped flit
//
// Flit layout (bits of the 34-bit flit):
//   [33:32] type  00 head+tail, 01 head, 11 body, 10 tail
//   [29:27] dst_x (head flits only)
//   [26:24] dst_y (head flits only)
// -----------------------------------------------------------------------------
module input_module #(
    parameter int N_VC       = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int ROUTER_X   = 0,
    parameter int ROUTER_Y   = 0
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [36:0]     fin_req_i,
    output logic [N_VC-1:0] fin_resp_o,
    output logic [36:0]     fout_req_o,
    output logic [4:0]      fout_route_o,
    input  logic            fout_resp_i,
    output logic            err_o
);

    localparam int VC_W   = 2;
    localparam int FLIT_W = 34;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    localparam logic [1:0] FT_SINGLE = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_BODY   = 2'b11;
    localparam logic [1:0] FT_TAIL   = 2'b10;

    localparam logic [4:0] RT_L = 5'b00001;
    localparam logic [4:0] RT_N = 5'b00010;
    localparam logic [4:0] RT_S = 5'b00100;
    localparam logic [4:0] RT_E = 5'b01000;
    localparam logic [4:0] RT_W = 5'b10000;

    // Dimension-ordered routing: resolve X first, then Y, then eject locally.
    function automatic logic [4:0] xy_route(input logic [2:0] dst_x, input logic [2:0] dst_y);
        logic [4:0] r;
        if (dst_x > 3'(ROUTER_X))      r = RT_E;
        else if (dst_x < 3'(ROUTER_X)) r = RT_W;
        else if (dst_y > 3'(ROUTER_Y)) r = RT_N;
        else if (dst_y < 3'(ROUTER_Y)) r = RT_S;
        else                           r = RT_L;
        return r;
    endfunction

    // (base + off) mod N_VC, with base and off both below N_VC.
    function automatic logic [VC_W-1:0] vc_add(input logic [VC_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_VC) sum = sum - N_VC;
        return VC_W'(sum);
    endfunction

    // ------------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------------
    logic              in_valid;
    logic [VC_W-1:0]   in_vc;
    logic [FLIT_W-1:0] in_flit;
    logic [1:0]        in_type;

    assign in_valid = fin_req_i[0];
    assign in_vc    = fin_req_i[2:1];
    assign in_flit  = fin_req_i[36:3];
    assign in_type  = fin_req_i[36:35];

    // ------------------------------------------------------------------------
    // Per-VC state
    // ------------------------------------------------------------------------
    logic [N_VC-1:0]   vc_sel;
    logic [N_VC-1:0]   vc_full;
    logic [N_VC-1:0]   vc_empty;
    logic [N_VC-1:0]   vc_push;
    logic [N_VC-1:0]   vc_pop;
    logic [N_VC-1:0]   vc_err;
    logic [FLIT_W-1:0] head_flit  [N_VC];
    logic [4:0]        head_route [N_VC];

    logic              out_valid;
    logic              pop_fire;
    logic [VC_W-1:0]   grant_vc;

    genvar gi;
    generate
        for (gi = 0; gi < N_VC; gi++) begin : gen_vc
            logic [FLIT_W-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0]     wr_ptr_q;
            logic [AW-1:0]     rd_ptr_q;
            logic [CW-1:0]     count_q;
            logic              open_q;
            logic [4:0]        route_q;
            logic              in_is_head;
            logic              proto_drop;
            logic [1:0]        head_type;
            logic              head_starts;

            assign vc_sel[gi]   = in_valid && (in_vc == VC_W'(gi));
            assign vc_full[gi]  = (count_q == CW'(FIFO_DEPTH));
            assign vc_empty[gi] = (count_q == '0);

            // A body or tail with no packet open has nowhere to belong.
            assign in_is_head = (in_type == FT_HEAD) || (in_type == FT_SINGLE);
            assign proto_drop = !open_q && ((in_type == FT_BODY) || (in_type == FT_TAIL));

            // Fullness comes from the registered count only, so a flit arriving
            // at a full FIFO is dropped even if that FIFO pops this same cycle.
            assign vc_push[gi] = vc_sel[gi] && !vc_full[gi] && !proto_drop;

            // A head arriving inside an open packet is kept (the packet restarts)
            // but still flagged.
            assign vc_err[gi]  = vc_sel[gi] &&
                                 (vc_full[gi] || proto_drop || (open_q && in_is_head));

            assign vc_pop[gi]  = pop_fire && (grant_vc == VC_W'(gi));

            // The FIFO head is read combinationally so a flit written at one
            // edge is on the output straight after it, with no bypass path.
            assign head_flit[gi] = mem[rd_ptr_q];
            assign head_type     = mem[rd_ptr_q][33:32];
            assign head_starts   = (head_type == FT_HEAD) || (head_type == FT_SINGLE);

            // Non-head flits inherit the port latched when their head left.
            assign head_route[gi] = head_starts ?
                                    xy_route(mem[rd_ptr_q][29:27], mem[rd_ptr_q][26:24]) :
                                    route_q;

            always_ff @(posedge clk) begin
                if (vc_push[gi]) begin
                    mem[wr_ptr_q] <= in_flit;
                end
            end

            always_ff @(posedge clk or negedge arst) begin
                if (!arst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    open_q   <= 1'b0;
                    route_q  <= '0;
                end else begin
                    if (vc_push[gi]) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        case (in_type)
                            FT_HEAD:            open_q <= 1'b1;
                            FT_SINGLE, FT_TAIL: open_q <= 1'b0;
                            default:            ;
                        endcase
                    end
                    if (vc_pop[gi]) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        if (head_type == FT_HEAD) begin
                            route_q <= xy_route(mem[rd_ptr_q][29:27], mem[rd_ptr_q][26:24]);
                        end
                    end
                    count_q <= count_q + CW'(vc_push[gi]) - CW'(vc_pop[gi]);
                end
            end
        end
    endgenerate

    assign fin_resp_o = ~vc_full;

    // ------------------------------------------------------------------------
    // Round-robin read arbitration with grant lock
    // ------------------------------------------------------------------------
    logic [VC_W-1:0] ptr_q;
    logic [VC_W-1:0] rr_vc;
    logic [VC_W-1:0] rr_cand;
    logic [VC_W-1:0] lock_vc_q;
    logic            lock_q;
    logic            err_q;
    logic            err_next;
    logic            bad_vc;

    // Walk from the farthest offset to the nearest so the VC closest to ptr wins.
    always_comb begin
        rr_vc   = ptr_q;
        rr_cand = '0;
        for (int k = N_VC - 1; k >= 0; k--) begin
            rr_cand = vc_add(ptr_q, k);
            for (int v = 0; v < N_VC; v++) begin
                if ((rr_cand == VC_W'(v)) && !vc_empty[v]) begin
                    rr_vc = rr_cand;
                end
            end
        end
    end

    // While an offered flit waits for the crossbar, keep offering the same VC
    // even if a VC nearer to ptr becomes non-empty, so nothing is retracted.
    assign out_valid = !(&vc_empty);
    assign grant_vc  = lock_q ? lock_vc_q : rr_vc;
    assign pop_fire  = out_valid && fout_resp_i;

    // Flits on VC ids beyond N_VC match no FIFO.
    assign bad_vc   = in_valid && !(|vc_sel);
    assign err_next = bad_vc || (|vc_err);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q     <= err_next;
            lock_q    <= out_valid && !fout_resp_i;
            lock_vc_q <= grant_vc;
            if (pop_fire) begin
                ptr_q <= vc_add(grant_vc, 1);
            end
        end
    end

    assign err_o = err_q;

    // ------------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------------
    logic [FLIT_W-1:0] sel_flit;
    logic [4:0]        sel_route;

    always_comb begin
        sel_flit     = '0;
        sel_route    = '0;
        fout_req_o   = '0;
        fout_route_o = '0;
        for (int v = 0; v < N_VC; v++) begin
            if (grant_vc == VC_W'(v)) begin
                sel_flit  = head_flit[v];
                sel_route = head_route[v];
            end
        end
        if (out_valid) begin
            fout_req_o   = {sel_flit, grant_vc, 1'b1};
            fout_route_o = sel_route;
        end
    end

endmodule

// File: tb/tb_input_module.sv
// -----------------------------------------------------------------------------
// tb_input_module
//
// Directed bench for input_module with N_VC=3, FIFO_DEPTH=4 and the router at
// (1,1). Inputs change 1 time unit after a rising edge; outputs are checked at
// the same point, i.e. after the edge has taken effect.
// -----------------------------------------------------------------------------
module tb_input_module;

    logic        clk;
    logic        arst;
    logic [36:0] fin_req;
    logic [2:0]  fin_resp;
    logic [36:0] fout_req;
    logic [4:0]  fout_route;
    logic        fout_resp;
    logic        err;

    int tests;
    int fails;

    input_module #(
        .N_VC       (3),
        .FIFO_DEPTH (4),
        .ROUTER_X   (1),
        .ROUTER_Y   (1)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .fin_req_i    (fin_req),
        .fin_resp_o   (fin_resp),
        .fout_req_o   (fout_req),
        .fout_route_o (fout_route),
        .fout_resp_i  (fout_resp),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] RT_L = 5'b00001;
    localparam logic [4:0] RT_N = 5'b00010;
    localparam logic [4:0] RT_S = 5'b00100;
    localparam logic [4:0] RT_E = 5'b01000;
    localparam logic [4:0] RT_W = 5'b10000;

    // Link word: {type, 2'b00, dst_x, dst_y, tag, vc, valid}; the crossbar side
    // uses the same packing, so an expected output is the word that was sent.
    function automatic logic [36:0] mk(input logic [1:0] vc, input logic [1:0] ft,
                                       input logic [2:0] dx, input logic [2:0] dy,
                                       input logic [23:0] tag);
        return {ft, 2'b00, dx, dy, tag, vc, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [36:0] h3, b3, t3;
    logic [36:0] s4 [5];
    logic [36:0] a5 [3];
    logic [36:0] b5 [3];

    initial begin
        tests     = 0;
        fails     = 0;
        arst      = 1'b0;
        fin_req   = '0;
        fout_resp = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_fout_req",   fout_req,   0);
        check("rst_fout_route", fout_route, 0);
        check("rst_err",        err,        0);
        check("rst_fin_resp",   fin_resp,   3'b111);
        arst = 1'b1;
        tick();

        // ---------------- single flit, local ----------------
        fin_req = mk(2'd1, 2'b00, 3'd1, 3'd1, 24'h000001);
        tick();
        fin_req = '0;
        check("single_req",   fout_req,   mk(2'd1, 2'b00, 3'd1, 3'd1, 24'h000001));
        check("single_route", fout_route, RT_L);
        check("single_err",   err,        0);
        fout_resp = 1'b1;
        tick();
        fout_resp = 1'b0;
        check("single_popped", fout_req, 0);
        $display("[TB] single flit vc1 -> L done");

        // ---------------- head/body/tail, held back ----------------
        h3 = mk(2'd0, 2'b01, 3'd3, 3'd0, 24'h000A01);
        b3 = mk(2'd0, 2'b11, 3'd0, 3'd0, 24'h000A02);  // payload would route W if misread
        t3 = mk(2'd0, 2'b10, 3'd0, 3'd0, 24'h000A03);
        fin_req = h3; tick();
        fin_req = b3; tick();
        fin_req = t3; tick();
        fin_req = '0;
        check("hbt_hold1_req",   fout_req,   h3);
        check("hbt_hold1_route", fout_route, RT_E);
        tick();
        check("hbt_hold2_req",   fout_req,   h3);
        tick();
        check("hbt_hold3_req",   fout_req,   h3);
        check("hbt_hold3_route", fout_route, RT_E);
        fout_resp = 1'b1;
        tick();
        check("hbt_body_req",   fout_req,   b3);
        check("hbt_body_route", fout_route, RT_E);
        tick();
        check("hbt_tail_req",   fout_req,   t3);
        check("hbt_tail_route", fout_route, RT_E);
        tick();
        fout_resp = 1'b0;
        check("hbt_empty", fout_req, 0);
        $display("[TB] head/body/tail vc0 -> E done");

        // ---------------- fill vc2 past depth ----------------
        for (int i = 0; i < 5; i++) begin
            s4[i] = mk(2'd2, 2'b00, 3'd1, 3'd2, 24'h000B00 + 24'(i));
        end
        for (int i = 0; i < 4; i++) begin
            fin_req = s4[i];
            tick();
        end
        check("full_resp", fin_resp, 3'b011);
        check("full_noerr", err, 0);
        fin_req = s4[4];
        tick();
        fin_req = '0;
        check("full_drop_err", err, 1);
        tick();
        check("full_err_clear", err, 0);
        check("full_resp_hold", fin_resp, 3'b011);
        check("full_head_req",   fout_req,   s4[0]);
        check("full_head_route", fout_route, RT_N);
        fout_resp = 1'b1;
        tick();
        check("full_pop1_req", fout_req, s4[1]);
        tick();
        tick();
        tick();
        fout_resp = 1'b0;
        check("full_drained_req",  fout_req, 0);
        check("full_drained_resp", fin_resp, 3'b111);
        $display("[TB] vc2 overflow drop done");

        // ---------------- round-robin interleave ----------------
        for (int i = 0; i < 3; i++) begin
            a5[i] = mk(2'd0, 2'b00, 3'd0, 3'd1, 24'h000C00 + 24'(i));
            b5[i] = mk(2'd2, 2'b00, 3'd1, 3'd0, 24'h000D00 + 24'(i));
        end
        for (int i = 0; i < 3; i++) begin
            fin_req = a5[i]; tick();
            fin_req = b5[i]; tick();
        end
        fin_req = '0;
        fout_resp = 1'b1;
        check("rr_a0_req",   fout_req,   a5[0]);
        check("rr_a0_route", fout_route, RT_W);
        tick();
        check("rr_b0_req",   fout_req,   b5[0]);
        check("rr_b0_route", fout_route, RT_S);
        tick();
        check("rr_a1_req", fout_req, a5[1]);
        tick();
        check("rr_b1_req", fout_req, b5[1]);
        tick();
        check("rr_a2_req", fout_req, a5[2]);
        tick();
        check("rr_b2_req", fout_req, b5[2]);
        tick();
        fout_resp = 1'b0;
        check("rr_empty", fout_req, 0);
        $display("[TB] round-robin vc0/vc2 done");

        // ---------------- protocol drops ----------------
        fin_req = mk(2'd1, 2'b11, 3'd0, 3'd0, 24'h000E01);
        tick();
        check("orphan_body_err", err, 1);
        fin_req = mk(2'd3, 2'b00, 3'd1, 3'd1, 24'h000E02);
        tick();
        check("bad_vc_err", err, 1);
        fin_req = '0;
        tick();
        check("drops_err_clear", err, 0);
        check("drops_req",       fout_req, 0);
        check("drops_resp",      fin_resp, 3'b111);
        $display("[TB] orphan body and bad vc done");

        // ---------------- reset with traffic ----------------
        fin_req = mk(2'd0, 2'b01, 3'd2, 3'd1, 24'h000F00);
        tick();
        for (int i = 0; i < 4; i++) begin
            fin_req = mk(2'd2, 2'b00, 3'd1, 3'd1, 24'h000F10 + 24'(i));
            tick();
        end
        fin_req = '0;
        check("pre_rst_resp",  fin_resp, 3'b011);
        check("pre_rst_valid", fout_req[0], 1);
        #2;
        arst = 1'b0;
        #1;
        check("async_rst_req",   fout_req,   0);
        check("async_rst_route", fout_route, 0);
        check("async_rst_resp",  fin_resp,   3'b111);
        @(posedge clk);
        #1;
        arst = 1'b1;
        tick();
        check("post_rst_req", fout_req, 0);
        fin_req = mk(2'd0, 2'b11, 3'd0, 3'd0, 24'h000F20);
        tick();
        fin_req = '0;
        check("post_rst_body_err", err, 1);
        tick();
        check("post_rst_body_req", fout_req, 0);
        $display("[TB] reset with traffic done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
